// File: rtl/axis_uart_tx.sv
// UART transmitter: valid/ready byte stream in, 8N1/8N2 serial line out.
// A new byte can be taken in the last stop-bit cycle, so frames run back to back.
module axis_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] idata,
  input  logic       ivalid,
  output logic       iready,
  output logic       txd,
  output logic       busy
);

  localparam int              CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic            STOP_MAX = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    sh_q, sh_d;
  logic          en_q;

  logic baud_end, last_stop, hs;

  assign baud_end  = (cnt_q == CNT_MAX);
  assign last_stop = (state_q == STOP) && baud_end && (stop_q == STOP_MAX);
  // en_q is the registered reset flag: keeps iready low while resetn is held
  assign iready    = en_q && ((state_q == IDLE) || last_stop);
  assign hs        = ivalid && iready;
  assign busy      = (state_q != IDLE);
  assign txd       = (state_q == START) ? 1'b0 :
                     (state_q == DATA)  ? sh_q[0] : 1'b1;

  always_ff @(posedge clock) begin
    en_q <= resetn;
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    sh_d    = sh_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          sh_d    = idata;
          cnt_d   = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          cnt_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) begin
            stop_d  = 1'b0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          cnt_d = '0;
          if (stop_q == STOP_MAX) begin
            stop_d = 1'b0;
            if (hs) begin
              sh_d    = idata;
              bit_d   = '0;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/axis_uart_tx.md
# axis_uart_tx

Byte-stream UART transmitter that consumes an AXI-Stream style valid/ready byte channel and serialises each byte onto a single asynchronous line (8N1 or 8N2). It sits directly downstream of the stream register stage and drains its output channel. It applies backpressure through `iready` while a frame is on the line. Back-to-back bytes are sent with zero idle gap.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per line bit; legal range >= 1.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.
- `clock`  input  1  system clock; all logic on rising edge.
- `resetn`  input  1  reset, synchronous, active-low; clock `clock`.
- `idata`  input  8  byte to send; sampled only on handshake.
- `ivalid`  input  1  upstream has a byte; must hold with stable `idata` until handshake.
- `iready`  output  1  block accepts a byte this cycle; handshake = `ivalid && iready`.
- `txd`  output  1  serial line; idle high.
- `busy`  output  1  high while a frame (start, data or stop bit) is being driven.

## Operation
- States: IDLE, START, DATA, STOP.
  - Baud counter: 0..`CLKS_PER_BIT`-1.
  - Bit index: 3 bits, 0..7.
  - Stop index: 0..`STOP_BITS`-1.
  - Shift register: 8 bits.
- IDLE:
  - `txd`=1, `busy`=0, `iready`=1.
  - On handshake: latch `idata`, clear the counters, go to START.
- START:
  - `txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA:
  - `txd` = shift register bit 0; LSB first.
  - After each `CLKS_PER_BIT` cycles, shift right and increment the bit index.
  - After bit 7, go to STOP.
- STOP:
  - `txd`=1 for `STOP_BITS`*`CLKS_PER_BIT` cycles.
- `iready` is also 1 during the final cycle of the final stop bit.
  - Handshake in that cycle: latch the byte and go directly to START (no idle gap).
  - No handshake in that cycle: go to IDLE.
- `iready` is 0 in all other START/DATA/STOP cycles. `iready` never depends on `ivalid`.
- `busy` = (state != IDLE). `txd`, `busy` and `iready` are registered-state decodes, with no combinational path from inputs.
- Counter arithmetic: the baud counter wraps from `CLKS_PER_BIT`-1 to 0. Size it as clog2(`CLKS_PER_BIT`), minimum 1 bit. No other overflow is possible.
- Reset (`resetn`=0 at a rising edge), including mid-frame:
  - Next state is IDLE and counters clear.
  - Any byte in flight is dropped; it is not resent.
  - Outputs while `resetn`=0 held: `txd`=1, `busy`=0, `iready`=0.
  - `iready`=0 is forced by gating with a registered reset flag, so no byte is accepted during reset.
  - `iready` rises on the first cycle after the first edge with `resetn`=1.

## Timing
- Notation: N = `CLKS_PER_BIT`, S = `STOP_BITS`. Handshake occurs at edge T.
- Cycle T+1 .. T+N: start bit, `txd`=0.
- Cycle T+1+(1+i)N .. T+(2+i)N: data bit i, for i=0..7.
- Cycle T+1+9N .. T+(9+S)N: stop bits, `txd`=1.
- `iready`=1 only in cycle T+(9+S)N within the frame.
- Frame period: (9+S)N cycles. Sustained throughput is one byte per (9+S)N cycles.
- Latency from handshake to start-bit falling edge: 1 cycle.

## Test plan
- Reset values: hold `resetn`=0 for 3 cycles with `ivalid`=1.
  - Required: `txd`=1, `iready`=0, `busy`=0 throughout; no frame afterwards is attributable to the reset-time data.
  - Release: `iready`=1 on the next cycle.
- Single byte: N=4, S=1, send 0xA5.
  - Required: `txd`, in 4-cycle groups = 0, 1,0,1,0,0,1,0,1, 1.
  - Then idle high; `busy` high exactly 40 cycles.
- Back-to-back: N=4, S=1, bytes 0x00 then 0xFF with `ivalid` constant high.
  - Required: second start bit begins on the cycle right after the first frame's 40th cycle.
  - Exactly 2 handshakes, 80 busy cycles, no idle cycle between frames.
- Two stop bits and N=1: S=2, send 0x3C.
  - Required: `txd` = 0,0,0,1,1,1,1,0,0,1,1 over 11 cycles.
  - `iready` high only on cycle 11 and after.
- Backpressure: assert `ivalid` with 0x11 during cycle T+5 of a frame carrying 0x80.
  - Required: no handshake until cycle T+(9+S)N.
  - 0x11 then goes out unchanged in the following frame.
- Reset mid-frame: assert `resetn`=0 for 1 cycle during data bit 3.
  - Required: `txd`=1 and `busy`=0 on the next cycle.
  - After release, the next accepted byte is sent as a complete fresh frame.
  - The aborted byte never reappears.
